// File: rtl/filler_pkg.sv
// rtl/filler_pkg.sv - shared conveyor state encoding and default timing constants
package filler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADVANCE   = 3'd1,
        SETTLE    = 3'd2,
        REQUEST   = 3'd3,
        WAIT_FILL = 3'd4,
        EJECT     = 3'd5,
        FAULT     = 3'd6
    } conveyor_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES   = 1;
    localparam int DEF_FILL_TIMEOUT    = 8;
    localparam int DEF_EJECT_CYCLES    = 2;
    localparam int DEF_BATCH_SIZE      = 6;
    localparam int DEF_COUNT_W         = 8;

    // Largest of three cycle limits, used to size the shared state-dwell counter
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// rtl/sensor_debouncer.sv - two-flop synchronizer plus run-length debounce of the bottle photo-sensor
module sensor_debouncer
    import filler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sensor_i,
    output logic present_o
);

    localparam int RUN_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             present_q, present_d;
    logic [RUN_W-1:0] run_q, run_d;

    // A sample disagreeing with the debounced level extends the run; an agreeing one restarts it
    always_comb begin
        present_d = present_q;
        run_d     = '0;
        if (sync_q[1] != present_q) begin
            if (run_q == RUN_LAST) begin
                present_d = sync_q[1];
            end else begin
                run_d = run_q + 1'b1;
            end
        end
    end

    // Synchronizer chain and debounce state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b00;
            present_q <= 1'b0;
            run_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], sensor_i};
            present_q <= present_d;
            run_q     <= run_d;
        end
    end

    assign present_o = present_q;

endmodule

// File: rtl/fsm_bottle_conveyor.sv
// rtl/fsm_bottle_conveyor.sv - Moore conveyor sequencer feeding the filler; BATCH_STOP_EN adds batch stop
module fsm_bottle_conveyor
    import filler_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SETTLE_CYCLES   = DEF_SETTLE_CYCLES,
    parameter int FILL_TIMEOUT    = DEF_FILL_TIMEOUT,
    parameter int EJECT_CYCLES    = DEF_EJECT_CYCLES,
`ifdef BATCH_STOP_EN
    parameter int BATCH_SIZE      = DEF_BATCH_SIZE,
`endif
    parameter int COUNT_W         = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               bottle_sensor,
    input  logic               lleno_flag,
    input  logic               clear_fault,
    output logic               conveyor_on,
    output logic               startfill,
    output logic [COUNT_W-1:0] bottle_count,
    output logic               batch_done,
    output logic               fault,
    output logic [2:0]         state_indicator
);

    // One dwell counter serves SETTLE, WAIT_FILL and EJECT; it restarts on every state change
    localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, FILL_TIMEOUT, EJECT_CYCLES));
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] EJECT_LAST   = CNT_W'(EJECT_CYCLES - 1);

    conveyor_state_t    state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               bottle_present;
    logic               eject_exit;
    logic               batch_hold;

    sensor_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk_i     (clk),
        .rst_ni    (rst),
        .sensor_i  (bottle_sensor),
        .present_o (bottle_present)
    );

`ifdef BATCH_STOP_EN
    localparam int BATCH_W = (BATCH_SIZE < 2) ? 1 : $clog2(BATCH_SIZE);
    localparam logic [BATCH_W-1:0] BATCH_LAST = BATCH_W'(BATCH_SIZE - 1);

    logic [BATCH_W-1:0] batch_cnt_q, batch_cnt_d;
    logic               batch_done_q, batch_done_d;
    logic               batch_full;

    // Count completed bottles; the last of a batch stops the line until the operator drops enable
    always_comb begin
        batch_cnt_d  = batch_cnt_q;
        batch_done_d = batch_done_q;
        batch_full   = 1'b0;
        if (eject_exit) begin
            if (batch_cnt_q == BATCH_LAST) begin
                batch_full   = 1'b1;
                batch_done_d = 1'b1;
                batch_cnt_d  = '0;
            end else begin
                batch_cnt_d = batch_cnt_q + 1'b1;
            end
        end
        if (batch_done_q && !enable) begin
            batch_done_d = 1'b0;
            batch_cnt_d  = '0;
        end
    end

    // Batch counter and completion flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            batch_cnt_q  <= '0;
            batch_done_q <= 1'b0;
        end else begin
            batch_cnt_q  <= batch_cnt_d;
            batch_done_q <= batch_done_d;
        end
    end

    assign batch_hold = batch_done_q;
    assign batch_done = batch_done_q;
`else
    assign batch_hold = 1'b0;
    assign batch_done = 1'b0;
`endif

    // Next-state, dwell counter and bottle counter
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        count_d    = count_q;
        eject_exit = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !batch_hold) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (bottle_present) state_d = SETTLE;
                else if (!enable)   state_d = IDLE;
            end
            SETTLE: begin
                if (!bottle_present)           state_d = ADVANCE;
                else if (cnt_q == SETTLE_LAST) state_d = REQUEST;
                else                           cnt_d   = cnt_q + 1'b1;
            end
            REQUEST: begin
                state_d = WAIT_FILL;
            end
            WAIT_FILL: begin
                // A done flag on the final allowed cycle still counts as a good fill
                if (lleno_flag)                 state_d = EJECT;
                else if (cnt_q == TIMEOUT_LAST) state_d = FAULT;
                else                            cnt_d   = cnt_q + 1'b1;
            end
            EJECT: begin
                if (cnt_q == EJECT_LAST) begin
                    if (!bottle_present) begin
                        eject_exit = 1'b1;
                        count_d    = count_q + 1'b1;
                        state_d    = enable ? ADVANCE : IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: begin
                if (clear_fault) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef BATCH_STOP_EN
        if (batch_full) state_d = IDLE;
`endif
        if (state_d != state_q) cnt_d = '0;
    end

    // State, dwell counter and bottle counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
        end
    end

    assign conveyor_on     = (state_q == ADVANCE) || (state_q == EJECT);
    assign startfill       = (state_q == REQUEST);
    assign fault           = (state_q == FAULT);
    assign bottle_count    = count_q;
    assign state_indicator = state_q;

endmodule

// File: doc/fsm_bottle_conveyor.md
Name: fsm_bottle_conveyor

Overview:
Moore FSM controlling the conveyor that feeds bottles into the filling station, directly upstream of the filler FSM.
- Advances the belt until a bottle is detected and settled.
- Issues a one-cycle startfill to the filler and waits for its lleno_flag.
- Ejects the filled bottle downstream, counts bottles, and flags fill timeouts.
- Runs on the system 1 Hz clock.

Parameters:
DEBOUNCE_CYCLES, 2, consecutive synchronized-high samples required to declare a bottle present (>=1)
SETTLE_CYCLES, 1, cycles belt stays off before requesting fill (>=1)
FILL_TIMEOUT, 8, max cycles in WAIT_FILL before fault (>=5)
EJECT_CYCLES, 2, minimum belt-on cycles in EJECT (>=1)
BATCH_SIZE, 6, bottles per batch (used only with the optional feature)
COUNT_W, 8, width of bottle counter

Ports:
clk  input  1  system clock (1 Hz)
rst  input  1  asynchronous, active-low reset
enable  input  1  operator run switch, level
bottle_sensor  input  1  raw photo-sensor, asynchronous, 1 = bottle at fill position
lleno_flag  input  1  filler done flag, one-cycle pulse
clear_fault  input  1  operator fault acknowledge, level
conveyor_on  output  1  belt motor drive
startfill  output  1  fill request to filler, one-cycle pulse
bottle_count  output  COUNT_W  filled bottles ejected since reset
batch_done  output  1  batch complete (optional feature only, else 0)
fault  output  1  fill timeout fault
state_indicator  output  3  current state encoding for LEDs

Behaviour:
- Reset: rst low asynchronously forces the following; all take effect immediately, including mid-fill.
  - state = IDLE
  - all counters = 0
  - conveyor_on = 0, startfill = 0, fault = 0, batch_done = 0
  - bottle_count = 0, state_indicator = 0
- Sensor path: 2-flop synchronizer, then debounce.
  - bottle_present sets after DEBOUNCE_CYCLES consecutive high samples.
  - It clears after DEBOUNCE_CYCLES consecutive low samples.
  - Any opposite sample restarts the run.
- All outputs are Moore (state-decoded or registered).
- State encoding: IDLE=0, ADVANCE=1, SETTLE=2, REQUEST=3, WAIT_FILL=4, EJECT=5, FAULT=6.
- IDLE: belt off. enable=1 -> ADVANCE.
- ADVANCE: conveyor_on=1.
  - bottle_present=1 -> SETTLE.
  - Otherwise enable=0 -> IDLE.
  - bottle_present has priority over enable=0.
- SETTLE: belt off. Counter reaching SETTLE_CYCLES -> REQUEST.
  - If bottle_present drops -> ADVANCE (bottle slipped).
- REQUEST: startfill=1 for exactly one cycle -> WAIT_FILL unconditionally.
- WAIT_FILL: belt off; enable ignored, so the bottle in progress always completes.
  - lleno_flag=1 -> EJECT.
  - Timeout counter reaching FILL_TIMEOUT with no lleno_flag -> FAULT.
  - lleno_flag in the same cycle as timeout: lleno_flag wins.
- EJECT: conveyor_on=1 until both EJECT_CYCLES have elapsed and bottle_present=0.
  - Exit to ADVANCE if enable=1, else IDLE.
  - On exit, bottle_count increments by 1 and wraps at 2^COUNT_W.
- FAULT: belt off, fault=1, no startfill.
  - clear_fault=1 -> IDLE.
  - The bottle stays in place; the next run settles and refills it.
- Illegal state encoding -> IDLE.
- Filler latency: lleno_flag arrives 4 cycles after the startfill cycle, within the default FILL_TIMEOUT.

Optional Feature:
BATCH_STOP_EN
- Defined: a batch counter counts EJECT exits.
  - On reaching BATCH_SIZE, the EJECT exit goes to IDLE regardless of enable, and batch_done=1.
  - batch_done holds until enable is seen low, which clears batch_done and the batch counter.
  - While batch_done=1, IDLE ignores enable.
- Undefined: no batch counter, batch_done tied 0, continuous operation.

Decomposition:
- Shared package filler_pkg holds:
  - conveyor_state_t enum with the fixed encodings above
  - default timing constants
- Sub-module sensor_debouncer: synchronizer plus debounce counter, parameter DEBOUNCE_CYCLES, output bottle_present.

Test Plan:
- Normal cycle: rst low then high; enable=1; bottle_sensor high from cycle 3; lleno_flag pulsed 4 cycles after startfill; sensor low during EJECT.
  - Expect ADVANCE(1) -> SETTLE(2) -> REQUEST(3) -> WAIT_FILL(4) -> EJECT(5) -> ADVANCE.
  - startfill high exactly 1 cycle; bottle_count=1.
- Sensor glitch: bottle_sensor high 1 cycle, then low, in ADVANCE.
  - Expect no SETTLE and conveyor_on stays 1.
- Timeout: never pulse lleno_flag.
  - Expect FAULT 8 cycles after entering WAIT_FILL; fault=1, conveyor_on=0.
  - clear_fault=1 -> IDLE, fault=0.
- Timeout tie: lleno_flag on the 8th WAIT_FILL cycle.
  - Expect EJECT, fault stays 0.
- Reset mid-fill: rst low during WAIT_FILL.
  - Expect all outputs 0 and state_indicator=0 immediately, without waiting for a clock edge.
- BATCH_STOP_EN: 6 normal cycles.
  - Expect IDLE with batch_done=1 despite enable=1.
  - Drop enable -> batch_done=0; raise enable -> ADVANCE; bottle_count=6.
